mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter between samming_cpu and ram_adapter.
- Lets instruction fetch and load/store share the single SRAM path through ram_adapter, so test_inst_rom can be retired.
- Arbitrates fixed-priority (data over instruction), latches each granted request, and forwards ram_adapter's ready/data back to the owning master.
- A watchdog aborts transactions that never see ready.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_watchdog.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master SRAM arbiter and its watchdog.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_INST_BUSY = 2'd1,
    ARB_DATA_BUSY = 2'd2
  } arb_state_e;

  localparam logic [3:0] ARB_SEL_ALL = 4'b1111;

  // A zero timeout still needs a 1-bit counter so the port list stays legal.
  function automatic int wd_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Busy-cycle counter that flags a transaction ram_adapter never completes.
module mem_bus_arbiter_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = wd_cnt_width(TIMEOUT_CYCLES);
  localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic             at_limit;

  assign at_limit = (cnt_q == LIMIT_C);

  // Saturates at the limit; with TIMEOUT_CYCLES=0 it never leaves zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !at_limit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (TIMEOUT_CYCLES > 0) && enable_i && at_limit;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter letting fetch and load/store share one ram_adapter port.
// state          | meaning
// ARB_IDLE       | no owner; ram_* outputs all zero; grants data over inst
// ARB_INST_BUSY  | latched fetch on ram_*; waiting for ram_ready_i or timeout
// ARB_DATA_BUSY  | latched load/store on ram_*; waiting for ram_ready_i or timeout
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_data_o,
  output logic              inst_ready_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_sel_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_ready_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ready_i,
  output logic              bus_err_o
);

  arb_state_e        state_q;
  logic              ce_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              bus_err_q;

  logic busy;
  logic grant;
  logic wd_expire;
  logic finish;
  logic inst_own;
  logic data_own;

  assign busy     = (state_q != ARB_IDLE);
  assign grant    = (state_q == ARB_IDLE) && (data_ce_i || inst_ce_i);
  assign finish   = busy && (ram_ready_i || wd_expire);
  assign inst_own = (state_q == ARB_INST_BUSY);
  assign data_own = (state_q == ARB_DATA_BUSY);

  mem_bus_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear_i (grant),
    .enable_i(busy && !ram_ready_i),
    .expire_o(wd_expire)
  );

  // Completion always returns to IDLE, giving the bubble that stops a master
  // still holding ce in its ready cycle from being granted twice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (data_ce_i) begin
            state_q <= ARB_DATA_BUSY;
            ce_q    <= 1'b1;
            we_q    <= data_we_i;
            sel_q   <= data_sel_i;
            addr_q  <= data_addr_i;
            wdata_q <= data_wdata_i;
          end else if (inst_ce_i) begin
            state_q <= ARB_INST_BUSY;
            ce_q    <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= ARB_SEL_ALL;
            addr_q  <= inst_addr_i;
            wdata_q <= '0;
          end
        end
        default: begin
          if (finish) begin
            state_q <= ARB_IDLE;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            if (wd_expire) begin
              bus_err_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign ram_ce_o   = ce_q;
  assign ram_we_o   = we_q;
  assign ram_sel_o  = sel_q;
  assign ram_addr_o = addr_q;
  assign ram_data_o = wdata_q;
  assign bus_err_o  = bus_err_q;

  // An aborted transaction completes with zero data rather than bus garbage.
  assign inst_ready_o = inst_own && finish;
  assign data_ready_o = data_own && finish;
  assign inst_data_o  = (inst_own && ram_ready_i) ? ram_data_i : '0;
  assign data_rdata_o = (data_own && ram_ready_i) ? ram_data_i : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level owner/age model.
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_ce_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] inst_data_o;
  logic        inst_ready_o;
  logic        data_ce_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_sel_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        data_ready_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = '0;
  logic        ram_ready_i = 1'b0;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i),
    .inst_data_o(inst_data_o), .inst_ready_o(inst_ready_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .data_ready_o(data_ready_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i),
    .bus_err_o(bus_err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Model: who owns the bus (0 none, 1 fetch, 2 load/store), the request it
  // was granted with, and how many busy cycles have already elapsed.
  int          m_owner;
  int          m_age;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_err;

  bit e_done, e_timeout, done_inst, done_data;
  bit i_req, d_req;

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_we = 1'b0; m_sel = '0;
    m_addr = '0; m_wdata = '0; m_err = 1'b0;
    e_done = 0; e_timeout = 0; done_inst = 0; done_data = 0;
  endtask

  task automatic check_outputs();
    bit busy;
    busy      = (m_owner != 0);
    e_timeout = busy && !ram_ready_i && (m_age + 1 == TO);
    e_done    = busy && (ram_ready_i || e_timeout);
    done_inst = (m_owner == 1) && e_done;
    done_data = (m_owner == 2) && e_done;
    check_eq("ram_ce",   32'(ram_ce_o),   32'(busy));
    check_eq("ram_we",   32'(ram_we_o),   busy ? 32'(m_we) : 32'd0);
    check_eq("ram_sel",  32'(ram_sel_o),  busy ? 32'(m_sel) : 32'd0);
    check_eq("ram_addr", ram_addr_o,      busy ? m_addr : 32'd0);
    check_eq("ram_data", ram_data_o,      busy ? m_wdata : 32'd0);
    check_eq("inst_ready", 32'(inst_ready_o), 32'(done_inst));
    check_eq("data_ready", 32'(data_ready_o), 32'(done_data));
    check_eq("inst_data", inst_data_o, (m_owner == 1 && ram_ready_i) ? ram_data_i : 32'd0);
    check_eq("data_rdata", data_rdata_o, (m_owner == 2 && ram_ready_i) ? ram_data_i : 32'd0);
    check_eq("bus_err", 32'(bus_err_o), 32'(m_err));
  endtask

  task automatic model_step();
    if (m_owner != 0) begin
      if (e_done) begin
        if (e_timeout) m_err = 1'b1;
        m_owner = 0;
      end else begin
        m_age++;
      end
    end else if (data_ce_i) begin
      m_owner = 2; m_age = 0; m_we = data_we_i; m_sel = data_sel_i;
      m_addr = data_addr_i; m_wdata = data_wdata_i;
    end else if (inst_ce_i) begin
      m_owner = 1; m_age = 0; m_we = 1'b0; m_sel = 4'b1111;
      m_addr = inst_addr_i; m_wdata = '0;
    end
  endtask

  task automatic drive_masters();
    if (done_inst) i_req = 0;
    if (done_data) d_req = 0;
    if (!i_req && $urandom_range(0, 2) == 0) begin
      i_req = 1;
      inst_addr_i = $urandom & 32'hFFFF_FFFC;
    end
    inst_ce_i = i_req;
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1;
      data_we_i    = 1'($urandom);
      data_sel_i   = 4'($urandom);
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;
    end else if (d_req && $urandom_range(0, 3) == 0) begin
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;
    end
    data_ce_i   = d_req;
    ram_ready_i = ($urandom_range(0, 99) < 35);
    ram_data_i  = $urandom;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_masters();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
    end
  endtask

  task automatic quiet_inputs();
    i_req = 0; d_req = 0;
    inst_ce_i = 1'b0; data_ce_i = 1'b0; ram_ready_i = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    i_req = 0; d_req = 0;
    // Reset held: requests and a stray ready must produce nothing.
    #3;
    inst_ce_i = 1'b1; data_ce_i = 1'b1; ram_ready_i = 1'b1; ram_data_i = 32'h3C01_1234;
    #1;
    check_outputs();
    quiet_inputs();
    @(negedge clk);
    rst = 1'b1;

    run_cycles(3000);

    // Reach a load/store in flight, then pull reset between clock edges.
    begin
      int k;
      for (k = 0; k < 5000 && m_owner != 2; k++) run_cycles(1);
      if (m_owner != 2) begin
        n_checks++;
        $display("FAIL reach_data_busy: got owner %0d expected 2", m_owner);
      end
    end
    @(negedge clk);
    ram_ready_i = 1'b1;
    ram_data_i  = 32'hA5A5_5A5A;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    quiet_inputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    run_cycles(1500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
